// File: rtl/one_hot_to_bin_pipe_if.sv
// Stream bundle between the one-hot encoder stage and the decoder.
// err_cnt_o is only present when ONE_HOT_ERR_CNT_EN is defined.
interface one_hot_to_bin_pipe_if #(
  parameter int BIN_W     = 4,
  parameter int ONE_HOT_W = 16
);
  logic                 in_valid_i;
  logic                 in_ready_o;
  logic [ONE_HOT_W-1:0] one_hot_i;
  logic                 out_valid_o;
  logic                 out_ready_i;
  logic [BIN_W-1:0]     bin_o;
  logic                 err_o;
`ifdef ONE_HOT_ERR_CNT_EN
  logic [7:0]           err_cnt_o;

  modport master (
    output in_valid_i, one_hot_i, out_ready_i,
    input  in_ready_o, out_valid_o, bin_o, err_o, err_cnt_o
  );
  modport slave (
    input  in_valid_i, one_hot_i, out_ready_i,
    output in_ready_o, out_valid_o, bin_o, err_o, err_cnt_o
  );
`else
  modport master (
    output in_valid_i, one_hot_i, out_ready_i,
    input  in_ready_o, out_valid_o, bin_o, err_o
  );
  modport slave (
    input  in_valid_i, one_hot_i, out_ready_i,
    output in_ready_o, out_valid_o, bin_o, err_o
  );
`endif
endinterface

// File: rtl/one_hot_to_bin_pipe.sv
// One-hot to binary decoder with a two-entry skid buffer and malformed-word flag.
// Define ONE_HOT_ERR_CNT_EN to build in the saturating 8-bit error counter.
module one_hot_to_bin_pipe #(
  parameter int BIN_W     = 4,
  parameter int ONE_HOT_W = 16
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  one_hot_to_bin_pipe_if.slave bus
);
  typedef struct packed {
    logic [BIN_W-1:0] bin;
    logic             err;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t state;
  entry_t main_q, skid_q, dec;
  logic   in_ready_q, out_valid_q;
  logic   acc, xfer;

  // Lowest set bit wins, so a multi-hot word still yields a stable index.
  always_comb begin
    dec = '0;
    for (int k = ONE_HOT_W-1; k >= 0; k--)
      if (bus.one_hot_i[k]) dec.bin = BIN_W'(k);
    dec.err = (bus.one_hot_i == '0) ||
              ((bus.one_hot_i & (bus.one_hot_i - ONE_HOT_W'(1))) != '0);
  end

  assign acc  = bus.in_valid_i && in_ready_q;
  assign xfer = out_valid_q && bus.out_ready_i;

  // Handshake outputs are registered alongside the state so nothing
  // combinational reaches the ports.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state       <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      main_q      <= '0;
      skid_q      <= '0;
    end else begin
      case (state)
        EMPTY: if (acc) begin
          main_q      <= dec;
          state       <= ONE;
          out_valid_q <= 1'b1;
        end
        ONE: begin
          if (acc && xfer) begin
            main_q <= dec;
          end else if (acc) begin
            skid_q     <= dec;
            state      <= FULL;
            in_ready_q <= 1'b0;
          end else if (xfer) begin
            state       <= EMPTY;
            out_valid_q <= 1'b0;
          end
        end
        FULL: if (xfer) begin
          main_q     <= skid_q;
          state      <= ONE;
          in_ready_q <= 1'b1;
        end
        default: begin
          state       <= EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready_o  = in_ready_q;
  assign bus.out_valid_o = out_valid_q;
  assign bus.bin_o       = main_q.bin;
  assign bus.err_o       = main_q.err;

`ifdef ONE_HOT_ERR_CNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk_i) begin
    if (reset_i)
      err_cnt_q <= '0;
    else if (xfer && main_q.err && err_cnt_q != 8'hFF)
      err_cnt_q <= err_cnt_q + 8'd1;
  end

  assign bus.err_cnt_o = err_cnt_q;
`endif
endmodule
